// File: rtl/text_pkg.sv
// Shared geometry, fill character, FSM state type and byte-position helper
// for the text buffer controller.
package text_pkg;

    localparam int ROWS   = 20;
    localparam int COLS   = 32;
    localparam int CHAR_W = 8;
    localparam int ROW_W  = 5;
    localparam int COL_W  = 5;
    localparam int LINE_W = COLS * CHAR_W;
    localparam int TXT_W  = ROWS * LINE_W;
    localparam int IDX_W  = 13;

    localparam logic [CHAR_W-1:0] FILL_CHAR = 8'h20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_t;

    // Column 0 sits in the top byte of a line, so the offset runs backwards.
    function automatic logic [COL_W+2:0] byte_lsb(input logic [COL_W-1:0] col);
        logic [COL_W-1:0] rev;
        rev      = COL_W'(COLS - 1) - col;
        byte_lsb = {rev, 3'b000};
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; the last-grant pointer advances only when
// grant_en accepts the grant.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] gnt
);

    logic last_r;  // 1: requester 1 was granted most recently

    // One-hot grant selection; on contention the requester not granted last wins.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11: begin
                if (last_r) begin
                    gnt = 2'b01;
                end else begin
                    gnt = 2'b10;
                end
            end
            default: gnt = 2'b00;
        endcase
    end

    // Last-grant pointer; reset favours requester 0 at the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r <= 1'b1;
        end else if (grant_en && (gnt != 2'b00)) begin
            last_r <= gnt[1];
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/text_buffer_ctrl.sv
// 20x32 character grid feeding the VGA text renderer: arbitrated character
// writes plus whole-screen clear. Optional commit gating: VBLANK_GATE_EN.
module text_buffer_ctrl
    import text_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic [ROW_W-1:0]   row0,
    input  logic [COL_W-1:0]   col0,
    input  logic [CHAR_W-1:0]  chr0,
    output logic               ack0,
    input  logic               req1,
    input  logic [ROW_W-1:0]   row1,
    input  logic [COL_W-1:0]   col1,
    input  logic [CHAR_W-1:0]  chr1,
    output logic               ack1,
    output logic               err,
    input  logic               clr_req,
    output logic               clr_done,
    output logic               busy,
    input  logic               vblank,
    output logic [TXT_W-1:0]   txt
);

    state_t              state_r, state_next_s;
    logic [TXT_W-1:0]    txt_r;
    logic [ROW_W-1:0]    row_h_r, row_cnt_r;
    logic [COL_W-1:0]    col_h_r;
    logic [CHAR_W-1:0]   chr_h_r;
    logic                id_h_r;
    logic                ack0_r, ack1_r, err_r, clr_done_r, busy_r;
    logic [1:0]          gnt_s;
    logic                grant_en_s, latch_s, commit_wr_s, clr_start_s;
    logic                clear_row_s, clr_last_s, commit_ok_s, in_range_s;
    logic [IDX_W-1:0]    wr_idx_s, clr_idx_s;

`ifdef VBLANK_GATE_EN
    assign commit_ok_s = vblank;
`else
    logic unused_vblank_s;
    assign unused_vblank_s = vblank;
    assign commit_ok_s     = 1'b1;
`endif

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      ({req1, req0}),
        .grant_en (grant_en_s),
        .gnt      (gnt_s)
    );

    assign in_range_s = ({1'b0, row_h_r} < 6'(ROWS)) && ({1'b0, col_h_r} < 6'(COLS));
    assign wr_idx_s   = IDX_W'(row_h_r) * IDX_W'(LINE_W) + IDX_W'(byte_lsb(col_h_r));
    assign clr_idx_s  = IDX_W'(row_cnt_r) * IDX_W'(LINE_W);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and control strobes; clear outranks character writes in IDLE.
    always_comb begin
        state_next_s = state_r;
        grant_en_s   = 1'b0;
        latch_s      = 1'b0;
        commit_wr_s  = 1'b0;
        clr_start_s  = 1'b0;
        clear_row_s  = 1'b0;
        clr_last_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (clr_req) begin
                    clr_start_s  = 1'b1;
                    state_next_s = CLEAR;
                end else if (req0 || req1) begin
                    grant_en_s   = 1'b1;
                    latch_s      = 1'b1;
                    state_next_s = WRITE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WRITE: begin
                if (commit_ok_s) begin
                    commit_wr_s  = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WRITE;
                end
            end
            CLEAR: begin
                if (commit_ok_s) begin
                    clear_row_s = 1'b1;
                    if (row_cnt_r == ROW_W'(ROWS - 1)) begin
                        clr_last_s   = 1'b1;
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = CLEAR;
                    end
                end else begin
                    state_next_s = CLEAR;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Datapath: hold registers, row counter, grid and registered status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            txt_r      <= {(ROWS * COLS){FILL_CHAR}};
            row_h_r    <= '0;
            col_h_r    <= '0;
            chr_h_r    <= '0;
            id_h_r     <= 1'b0;
            row_cnt_r  <= '0;
            ack0_r     <= 1'b0;
            ack1_r     <= 1'b0;
            err_r      <= 1'b0;
            clr_done_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            ack0_r     <= commit_wr_s && !id_h_r;
            ack1_r     <= commit_wr_s && id_h_r;
            err_r      <= commit_wr_s && !in_range_s;
            clr_done_r <= clr_last_s;
            busy_r     <= (state_next_s != IDLE);
            if (latch_s) begin
                id_h_r  <= gnt_s[1];
                row_h_r <= gnt_s[1] ? row1 : row0;
                col_h_r <= gnt_s[1] ? col1 : col0;
                chr_h_r <= gnt_s[1] ? chr1 : chr0;
            end
            if (clr_start_s) begin
                row_cnt_r <= '0;
            end else if (clear_row_s) begin
                row_cnt_r <= row_cnt_r + 5'd1;
            end else begin
                row_cnt_r <= row_cnt_r;
            end
            if (commit_wr_s && in_range_s) begin
                txt_r[wr_idx_s +: CHAR_W] <= chr_h_r;
            end
            if (clear_row_s) begin
                txt_r[clr_idx_s +: LINE_W] <= {COLS{FILL_CHAR}};
            end
        end
    end

    assign txt      = txt_r;
    assign ack0     = ack0_r;
    assign ack1     = ack1_r;
    assign err      = err_r;
    assign clr_done = clr_done_r;
    assign busy     = busy_r;

endmodule
